// File: rtl/uart_rx_axis_if.sv
// uart_rx_axis_if: AXI-stream byte channel
// carrying received UART bytes downstream.
interface uart_rx_axis_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (
      output tdata,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 8N1 UART receiver, 8x oversampled,
// bytes presented on an AXI-stream master port.
module uart_rx_axis #(
   parameter int DATA_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           rxd,
   input  logic [15:0]    prescale,
   uart_rx_axis_if.master m_axis,
   output logic           busy,
   output logic           frame_error,
   output logic           overrun_error
);
   localparam int BW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                state;
   state_t                state_n;
   logic                  rxd_m;
   logic                  rxd_s;
   logic                  armed;
   logic [15:0]           psc;
   logic [18:0]           cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  tick;
   logic                  start_det;
   logic                  last_bit;

   // next-state decode and start/tick strobes
   always_comb begin
      state_n   = state;
      start_det = 1'b0;
      tick      = (cnt == '0);
      last_bit  = (bit_cnt == BW'(1));
      unique case (state)
         IDLE: begin
            if (armed && !rxd_s && prescale != 16'd0) begin
               start_det = 1'b1;
               state_n   = START;
            end
         end
         START: begin
            if (tick) state_n = rxd_s ? IDLE : DATA;
         end
         DATA: begin
            if (tick && last_bit) state_n = STOP;
         end
         STOP: begin
            if (tick) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // synchronizer, bit timing, shifter and output slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxd_m         <= 1'b1;
         rxd_s         <= 1'b1;
         armed         <= 1'b0;
         psc           <= '0;
         cnt           <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         busy          <= 1'b0;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
         m_axis.tdata  <= '0;
         m_axis.tvalid <= 1'b0;
      end else begin
         rxd_m         <= rxd;
         rxd_s         <= rxd_m;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
         if (m_axis.tvalid && m_axis.tready)
            m_axis.tvalid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rxd_s) armed <= 1'b1;
               if (start_det) begin
                  armed <= 1'b0;
                  psc   <= prescale;
                  cnt   <= {1'b0, prescale, 2'b00} - 19'd1;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (!tick) begin
                  cnt <= cnt - 19'd1;
               end else if (rxd_s) begin
                  busy <= 1'b0;
               end else begin
                  cnt     <= {psc, 3'b000} - 19'd1;
                  bit_cnt <= BW'(DATA_WIDTH);
               end
            end
            DATA: begin
               if (tick) begin
                  shreg   <= {rxd_s, shreg[DATA_WIDTH-1:1]};
                  cnt     <= {psc, 3'b000} - 19'd1;
                  bit_cnt <= bit_cnt - BW'(1);
               end else begin
                  cnt <= cnt - 19'd1;
               end
            end
            STOP: begin
               if (!tick) begin
                  cnt <= cnt - 19'd1;
               end else begin
                  busy <= 1'b0;
                  if (!rxd_s) begin
                     frame_error <= 1'b1;
                  end else if (!m_axis.tvalid || m_axis.tready) begin
                     m_axis.tdata  <= shreg;
                     m_axis.tvalid <= 1'b1;
                  end else begin
                     overrun_error <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
- UART receiver: the stage directly downstream of the team's AXI-stream UART transmitter. It consumes a serial txd line on rxd and presents each byte on an AXI-stream master port.
- Frame format: 8N1 (1 start, DATA_WIDTH data bits LSB first, 1 stop). Timing is 8x oversampled; one bit period is prescale*8 clocks, matching the TX side.
- Framing errors and overruns are reported as single-cycle pulses.

Parameters:
DATA_WIDTH, 8, number of data bits per frame and width of m_axis_tdata

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
rxd  input  1  serial line, asynchronous to clk, idle high
prescale  input  16  bit period = prescale*8 clocks
m_axis_tdata  output  DATA_WIDTH  received byte
m_axis_tvalid  output  1  byte available
m_axis_tready  input  1  downstream accepts
busy  output  1  frame in progress
frame_error  output  1  one-cycle pulse, stop bit sampled low
overrun_error  output  1  one-cycle pulse, byte dropped because output still occupied

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - Outputs: m_axis_tdata=0, m_axis_tvalid=0, busy=0, frame_error=0, overrun_error=0.
  - Internal: synchronizer flops=1, state=IDLE, counters=0, armed=0.
  - Reset mid-frame abandons the frame; no partial byte and no error pulses.
- Input sync: rxd passes through 2 flops, giving rxd_s. All decisions use rxd_s.
- Prescale handling:
  - prescale is sampled at start detection and held for the whole frame.
  - Prescale counter is 19 bits.
  - prescale=0: block stays in IDLE and never starts a frame.
- armed flag: set whenever rxd_s=1 in IDLE; cleared on start detection. A line held low never retriggers.
- FSM:
  - IDLE: if armed and rxd_s=0 and prescale!=0, then cnt<=(prescale<<2)-1 (half bit), busy<=1, go to START.
  - START: when cnt reaches 0, sample rxd_s.
    - Sample 0: cnt<=(prescale<<3)-1, bit_cnt<=DATA_WIDTH, go to DATA.
    - Sample 1 (false start/glitch): busy<=0, go to IDLE, no output.
  - DATA: when cnt reaches 0, shreg<={rxd_s, shreg[DATA_WIDTH-1:1]}, reload cnt, decrement bit_cnt. After the last bit go to STOP.
  - STOP: when cnt reaches 0, sample rxd_s, then busy<=0 and go to IDLE.
    - Stop=1: commit shreg.
    - Stop=0: frame_error<=1 for one cycle; byte discarded.
- Commit rules (evaluated in the stop-sample cycle):
  - If m_axis_tvalid=0, or m_axis_tvalid&&m_axis_tready in that same cycle: tdata<=shreg, tvalid<=1.
  - Otherwise: byte dropped, tdata/tvalid unchanged, overrun_error<=1 for one cycle.
- Latency: tvalid and the byte are visible the clock after the stop-sample edge.
- AXI rules:
  - tvalid stays high and tdata stays stable until a cycle with tready=1. That cycle clears tvalid unless a commit coincides.
  - tvalid never depends combinationally on tready.
- Error pulses never coincide with a valid commit of the same frame.

Test Plan:
- prescale=2 (16-clk bit), tready=1, send 0xA5 -> one beat tdata=0xA5; tvalid rises about 152 clks after the start edge (+2 sync); busy spans the frame; no error pulses.
- tready=0, send 0x3C then 0x81, then tready=1 -> tdata holds 0x3C throughout; overrun_error pulses once at the 0x81 stop sample; exactly one beat (0x3C) is accepted; 0x81 never appears.
- Send 0x55 with stop bit low, then hold rxd low 100 clks -> frame_error one pulse; tvalid stays 0; no new frame until rxd returns high; a following 0x12 is received correctly.
- rxd low glitch of 4 clks (prescale=2) -> false start; busy high for about 8 clks then 0; no beat; no errors.
- rst_n low for 1 cycle during data bit 3 of 0xF0 -> all outputs 0 the next cycle; a subsequent full 0xF0 frame is received correctly.
- Back-to-back 0x00 then 0xFF (one stop bit each), tready=1 -> two beats in order, 0x00 then 0xFF; no overrun.
